// File: rtl/scramble_pkg.sv
// Shared types and constants for the scramble move generator and its LFSR.
package scramble_pkg;

   localparam int          CODE_W       = 4;
   localparam int          NUM_CODES    = 12;
   localparam logic [15:0] LFSR_TAPS    = 16'hB400;
   localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GEN     = 2'd1,
      PRESENT = 2'd2,
      DONE    = 2'd3
   } state_t;

   // Codes (2k, 2k+1) undo each other.
   function automatic logic [CODE_W-1:0] inverse(input logic [CODE_W-1:0] code);
      return code ^ CODE_W'(1);
   endfunction

endpackage

// File: rtl/scramble_move_gen_if.sv
// Request/move handshake between the shuffle block, the generator and the state updater.
interface scramble_move_gen_if;
   import scramble_pkg::*;

   logic              rand_req;
   logic              move_valid;
   logic              move_ready;
   logic [CODE_W-1:0] move_code;
   logic              busy;
   logic              done;

   modport master (
      input  rand_req,
      input  move_ready,
      output move_valid,
      output move_code,
      output busy,
      output done
   );

   modport slave (
      output rand_req,
      output move_ready,
      input  move_valid,
      input  move_code,
      input  busy,
      input  done
   );

endinterface

// File: rtl/lfsr16.sv
// Free-running 16-bit right-shifting Galois LFSR; a zero seed falls back to the default.
module lfsr16
   import scramble_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] seed,
   output logic [15:0] q
);

   logic [15:0] r_lfsr;
   logic [15:0] w_seed;

   // All-zero is the lock-up state, so it can never be loaded.
   assign w_seed = (seed == 16'h0000) ? DEFAULT_SEED : seed;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_lfsr <= w_seed;
      end else begin
         r_lfsr <= {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? LFSR_TAPS : 16'h0000);
      end
   end

   assign q = r_lfsr;

endmodule

// File: rtl/scramble_move_gen.sv
// Emits a burst of NUM_MOVES legal, non-self-cancelling moves on each rising rand_req seen in IDLE.
module scramble_move_gen
   import scramble_pkg::CODE_W;
   import scramble_pkg::DEFAULT_SEED;
   import scramble_pkg::state_t;
   import scramble_pkg::IDLE;
   import scramble_pkg::GEN;
   import scramble_pkg::PRESENT;
   import scramble_pkg::DONE;
   import scramble_pkg::inverse;
#(
   parameter int          NUM_MOVES = 31,
   parameter logic [15:0] SEED      = DEFAULT_SEED,
   parameter int          NUM_CODES = scramble_pkg::NUM_CODES
) (
   input  logic                 clk,
   input  logic                 rst_n,
   scramble_move_gen_if.master  bus
);

   localparam int                CNT_W    = $clog2(NUM_MOVES + 1);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(NUM_MOVES - 1);
   localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(NUM_MOVES);
   localparam logic [CODE_W:0]   CODE_LIM = (CODE_W + 1)'(NUM_CODES);

   state_t              r_state;
   logic                r_req_prev;
   logic [CNT_W-1:0]    r_count;
   logic                r_prev_valid;
   logic [CODE_W-1:0]   r_prev_code;
   logic                r_move_valid;
   logic [CODE_W-1:0]   r_move_code;
   logic                r_busy;
   logic                r_done;

   logic [15:0]         w_lfsr;
   logic [CODE_W-1:0]   w_cand;
   logic                w_reject;
   logic                w_start;
   logic                w_unused;

   lfsr16 u_lfsr (
      .clk   (clk),
      .rst_n (rst_n),
      .seed  (SEED),
      .q     (w_lfsr)
   );

   assign w_cand   = w_lfsr[CODE_W-1:0];
   assign w_unused = ^w_lfsr[15:CODE_W];
   assign w_start  = bus.rand_req & ~r_req_prev;

   // Plain repeats are allowed; only out-of-range codes and immediate undo moves are retried.
   assign w_reject = ({1'b0, w_cand} >= CODE_LIM) ||
                     (r_prev_valid && (w_cand == inverse(r_prev_code)));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state      <= IDLE;
         r_req_prev   <= 1'b0;
         r_count      <= '0;
         r_prev_valid <= 1'b0;
         r_prev_code  <= '0;
         r_move_valid <= 1'b0;
         r_move_code  <= '0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
      end else begin
         r_req_prev <= bus.rand_req;
         r_done     <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_start) begin
                  r_state      <= GEN;
                  r_count      <= '0;
                  r_prev_valid <= 1'b0;
                  r_busy       <= 1'b1;
               end
            end
            GEN: begin
               if (!w_reject) begin
                  r_move_code  <= w_cand;
                  r_prev_code  <= w_cand;
                  r_prev_valid <= 1'b1;
                  r_move_valid <= 1'b1;
                  r_state      <= PRESENT;
               end
            end
            PRESENT: begin
               if (bus.move_ready) begin
                  r_move_valid <= 1'b0;
                  if (r_count != CNT_MAX) begin
                     r_count <= r_count + CNT_W'(1);
                  end
                  // busy drops together with the done pulse
                  if (r_count == CNT_LAST) begin
                     r_state <= DONE;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                  end else begin
                     r_state <= GEN;
                  end
               end
            end
            DONE: begin
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign bus.move_valid = r_move_valid;
   assign bus.move_code  = r_move_code;
   assign bus.busy       = r_busy;
   assign bus.done       = r_done;

endmodule

// File: tb/tb_scramble_move_gen.sv
// Randomised self-checking bench for scramble_move_gen against a cycle-anchored LFSR move model.
module tb_scramble_move_gen;

   localparam int NM = 31;
   localparam int NC = 12;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   scramble_move_gen_if bus0 ();
   scramble_move_gen_if bus1 ();

   scramble_move_gen #(.NUM_MOVES(NM), .SEED(16'hACE1), .NUM_CODES(NC)) dut0 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus0)
   );

   scramble_move_gen #(.NUM_MOVES(1), .SEED(16'h0001), .NUM_CODES(NC)) dut1 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus1)
   );

   function automatic logic [15:0] lfsr_next(input logic [15:0] v);
      return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
   endfunction

   function automatic bit legal(input bit pv, input logic [3:0] pc, input logic [3:0] c);
      return (int'(c) < NC) && !(pv && (c == (pc ^ 4'd1)));
   endfunction

   // Reference LFSR values for the cycle following each clock edge.
   logic [15:0] m0, m1;
   always @(posedge clk) begin
      m0 <= !rst_n ? 16'hACE1 : lfsr_next(m0);
      m1 <= !rst_n ? 16'h0001 : lfsr_next(m1);
   end

   logic [3:0] first_code;

   task automatic test_reset();
      rst_n = 1'b0;
      bus0.rand_req = 1'b0; bus0.move_ready = 1'b0;
      bus1.rand_req = 1'b0; bus1.move_ready = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         checks++;
         if ({bus0.move_valid, bus0.busy, bus0.done, bus0.move_code} !== 7'b0) begin
            failures++;
            $display("FAIL reset_idle cyc=%0d got valid=%b busy=%b done=%b code=%0d want all 0",
                     i, bus0.move_valid, bus0.busy, bus0.done, bus0.move_code);
         end
      end
      $display("test_reset: 50 idle cycles checked");
   endtask

   // first_mode: 0 record first move, 1 compare against recorded, 2 ignore
   task automatic test_burst(input int gap, input int stall_after, input int edge_after,
                             input bit done_edge, input int first_mode);
      logic [15:0] l;
      logic [3:0]  pc, exp_code;
      bit          pv;
      int          k;
      repeat (gap) @(negedge clk);
      @(negedge clk);
      bus0.rand_req = 1'b1; bus0.move_ready = 1'b1;
      @(negedge clk);
      pv = 1'b0; pc = 4'd0;
      for (int m = 0; m < NM; m++) begin
         l = m0; k = 0;
         while (!legal(pv, pc, l[3:0]) && k < 200) begin
            l = lfsr_next(l); k++;
         end
         for (int j = 0; j <= k; j++) begin
            checks++;
            if (bus0.move_valid !== 1'b0 || bus0.busy !== 1'b1 || bus0.done !== 1'b0) begin
               failures++;
               $display("FAIL gen_wait move=%0d j=%0d got valid=%b busy=%b done=%b want 0/1/0",
                        m, j, bus0.move_valid, bus0.busy, bus0.done);
            end
            @(negedge clk);
         end
         exp_code = l[3:0];
         checks++;
         if (bus0.move_valid !== 1'b1 || bus0.move_code !== exp_code) begin
            failures++;
            $display("FAIL move move=%0d got valid=%b code=%0d want valid=1 code=%0d",
                     m, bus0.move_valid, bus0.move_code, exp_code);
         end
         checks++;
         if (int'(bus0.move_code) >= NC || (pv && bus0.move_code == (pc ^ 4'd1))) begin
            failures++;
            $display("FAIL move_rule move=%0d got code=%0d prev=%0d want legal non-inverse",
                     m, bus0.move_code, pc);
         end
         if (m == 0 && first_mode == 0) first_code = bus0.move_code;
         if (m == 0 && first_mode == 1) begin
            checks++;
            if (bus0.move_code !== first_code) begin
               failures++;
               $display("FAIL first_after_reset got code=%0d want %0d", bus0.move_code, first_code);
            end
         end
         $display("move %0d code=%0d retries=%0d", m, bus0.move_code, k);
         if (m == stall_after) begin
            bus0.move_ready = 1'b0;
            repeat (10) begin
               @(negedge clk);
               checks++;
               if (bus0.move_valid !== 1'b1 || bus0.move_code !== exp_code || bus0.busy !== 1'b1) begin
                  failures++;
                  $display("FAIL stall got valid=%b code=%0d busy=%b want 1/%0d/1",
                           bus0.move_valid, bus0.move_code, bus0.busy, exp_code);
               end
            end
            bus0.move_ready = 1'b1;
         end
         if (m == edge_after - 1) bus0.rand_req = 1'b0;
         if (m == edge_after)     bus0.rand_req = 1'b1;
         if (done_edge && m == NM - 1) bus0.rand_req = 1'b0;
         pv = 1'b1; pc = exp_code;
         @(negedge clk);
      end
      checks++;
      if (bus0.done !== 1'b1 || bus0.busy !== 1'b0 || bus0.move_valid !== 1'b0) begin
         failures++;
         $display("FAIL done_pulse got done=%b busy=%b valid=%b want 1/0/0",
                  bus0.done, bus0.busy, bus0.move_valid);
      end
      if (done_edge) bus0.rand_req = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checks++;
         if (bus0.done !== 1'b0 || bus0.busy !== 1'b0 || bus0.move_valid !== 1'b0) begin
            failures++;
            $display("FAIL after_done cyc=%0d got done=%b busy=%b valid=%b want 0/0/0",
                     i, bus0.done, bus0.busy, bus0.move_valid);
         end
      end
      bus0.rand_req = 1'b0;
      @(negedge clk);
      $display("burst done: stall_after=%0d edge_after=%0d done_edge=%0d", stall_after, edge_after, done_edge);
   endtask

   task automatic test_reset_mid();
      int hs, cyc;
      hs = 0; cyc = 0;
      bus0.move_ready = 1'b1;
      @(negedge clk);
      bus0.rand_req = 1'b1;
      while (hs < 10 && cyc < 500) begin
         @(negedge clk);
         cyc++;
         if (bus0.move_valid === 1'b1 && bus0.move_ready === 1'b1) hs++;
      end
      checks++;
      if (hs != 10) begin
         failures++;
         $display("FAIL reset_mid_progress got %0d handshakes want 10", hs);
      end
      @(negedge clk);
      rst_n = 1'b0; bus0.rand_req = 1'b0;
      @(negedge clk);
      checks++;
      if ({bus0.move_valid, bus0.busy, bus0.done, bus0.move_code} !== 7'b0) begin
         failures++;
         $display("FAIL reset_mid_outputs got valid=%b busy=%b done=%b code=%0d want all 0",
                  bus0.move_valid, bus0.busy, bus0.done, bus0.move_code);
      end
      rst_n = 1'b1;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         checks++;
         if ({bus0.move_valid, bus0.busy, bus0.done} !== 3'b0) begin
            failures++;
            $display("FAIL reset_mid_idle cyc=%0d got valid=%b busy=%b done=%b want 0/0/0",
                     i, bus0.move_valid, bus0.busy, bus0.done);
         end
      end
      $display("reset mid-burst after %0d moves", hs);
      test_burst(0, -1, -1, 1'b0, 1);
   endtask

   task automatic test_single();
      logic [15:0] l;
      int k, st;
      for (int r = 0; r < 4; r++) begin
         st = int'($urandom_range(0, 3));
         repeat ($urandom_range(0, 6)) @(negedge clk);
         @(negedge clk);
         bus1.rand_req = 1'b1; bus1.move_ready = 1'b0;
         @(negedge clk);
         l = m1; k = 0;
         while (!legal(1'b0, 4'd0, l[3:0]) && k < 200) begin
            l = lfsr_next(l); k++;
         end
         for (int j = 0; j <= k; j++) begin
            checks++;
            if (bus1.move_valid !== 1'b0 || bus1.busy !== 1'b1) begin
               failures++;
               $display("FAIL single_wait r=%0d got valid=%b busy=%b want 0/1", r, bus1.move_valid, bus1.busy);
            end
            @(negedge clk);
         end
         for (int j = 0; j <= st; j++) begin
            checks++;
            if (bus1.move_valid !== 1'b1 || bus1.move_code !== l[3:0]) begin
               failures++;
               $display("FAIL single_move r=%0d got valid=%b code=%0d want 1/%0d",
                        r, bus1.move_valid, bus1.move_code, l[3:0]);
            end
            if (j == st) bus1.move_ready = 1'b1;
            @(negedge clk);
         end
         checks++;
         if (bus1.done !== 1'b1 || bus1.busy !== 1'b0 || bus1.move_valid !== 1'b0) begin
            failures++;
            $display("FAIL single_done r=%0d got done=%b busy=%b valid=%b want 1/0/0",
                     r, bus1.done, bus1.busy, bus1.move_valid);
         end
         bus1.rand_req = 1'b0; bus1.move_ready = 1'b0;
         @(negedge clk);
         checks++;
         if (bus1.done !== 1'b0) begin
            failures++;
            $display("FAIL single_done_len r=%0d got done=%b want 0", r, bus1.done);
         end
         $display("single r=%0d code=%0d retries=%0d stall=%0d", r, l[3:0], k, st);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_burst(0, -1, -1, 1'b0, 0);
      test_burst(int'($urandom_range(0, 5)), 7, -1, 1'b0, 2);
      test_burst(int'($urandom_range(0, 5)), -1, 5, 1'b1, 2);
      test_burst(int'($urandom_range(0, 5)), int'($urandom_range(0, NM - 1)), -1, 1'b0, 2);
      test_reset_mid();
      test_single();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
